// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle for the two-source round-robin feeder: two valid/ready inputs,
// one registered valid/ready output, and the grant (sel) exported to the 2:1 mux.
interface mux_rr_arbiter_if #(
  parameter int DATA_W = 2
);
  logic [DATA_W-1:0] in0_data;
  logic              in0_valid;
  logic              in0_ready;
  logic [DATA_W-1:0] in1_data;
  logic              in1_valid;
  logic              in1_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              sel;

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, out_data, out_valid, sel
  );

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, out_data, out_valid, sel
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Burst-limited round-robin arbiter between two valid/ready sources feeding one
// registered output beat per cycle; sel tracks the channel of the last accepted beat.
module mux_rr_arbiter #(
  parameter int DATA_W    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            resetn,
  mux_rr_arbiter_if.slave bus
);
  localparam int               CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_sel;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_data_p1;

  logic w_load_en;
  logic w_gnt_vld;
  logic w_gnt;
  logic w_rdy0;
  logic w_rdy1;
  logic w_acc;
  logic w_cont;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt < BURST_MAX) ? cnt + CNT_W'(1) : BURST_MAX;
  endfunction

  assign w_load_en = !r_vld_p1 || bus.out_ready;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 1'b0;
    if (bus.in0_valid && bus.in1_valid) begin
      w_gnt_vld = 1'b1;
      case (r_state)
        OWN0:    w_gnt = (r_burst_cnt < BURST_MAX) ? 1'b0 : 1'b1;
        OWN1:    w_gnt = (r_burst_cnt < BURST_MAX) ? 1'b1 : 1'b0;
        default: w_gnt = !r_sel;
      endcase
    end else if (bus.in0_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt     = 1'b0;
    end else if (bus.in1_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt     = 1'b1;
    end
  end

  assign w_rdy0 = w_load_en && resetn && w_gnt_vld && !w_gnt;
  assign w_rdy1 = w_load_en && resetn && w_gnt_vld &&  w_gnt;
  assign w_acc  = (bus.in0_valid && w_rdy0) || (bus.in1_valid && w_rdy1);

  // Same channel while already owning it keeps counting; anything else restarts the burst.
  assign w_cont = (w_gnt == r_sel) && (r_state == (w_gnt ? OWN1 : OWN0));

  // Stage boundary: accepted beat -> output register (p1)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_sel       <= 1'b0;
      r_burst_cnt <= '0;
      r_vld_p1    <= 1'b0;
      r_data_p1   <= '0;
    end else if (w_acc) begin
      r_data_p1   <= w_gnt ? bus.in1_data : bus.in0_data;
      r_vld_p1    <= 1'b1;
      r_sel       <= w_gnt;
      r_state     <= w_gnt ? OWN1 : OWN0;
      r_burst_cnt <= w_cont ? sat_inc(r_burst_cnt) : CNT_W'(1);
    end else begin
      if (r_vld_p1 && bus.out_ready) begin
        r_vld_p1 <= 1'b0;
      end
      if (!bus.in0_valid && !bus.in1_valid) begin
        r_state     <= IDLE;
        r_burst_cnt <= '0;
      end
    end
  end

  assign bus.in0_ready = w_rdy0;
  assign bus.in1_ready = w_rdy1;
  assign bus.out_data  = r_data_p1;
  assign bus.out_valid = r_vld_p1;
  assign bus.sel       = r_sel;
endmodule
